// File: rtl/mux_4to1_assign_if.sv
// Bus bundle for the 4-to-1 steering mux: channel data and select in,
// combinational/registered selection, change strobe and usage counters out.
interface mux_4to1_assign_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_vld;
  logic             sel_chg;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_c;
  logic [CNT_W-1:0] cnt_d;

  modport master (
    output en, a, b, c, d, sel,
    input  out, out_q, out_vld, sel_chg, cnt_a, cnt_b, cnt_c, cnt_d
  );

  modport slave (
    input  en, a, b, c, d, sel,
    output out, out_q, out_vld, sel_chg, cnt_a, cnt_b, cnt_c, cnt_d
  );
endinterface

// File: rtl/mux_4to1_assign.sv
// 4-input mux with a zero-latency output, a registered copy, a select-change
// strobe and per-channel saturating usage counters.
module mux_4to1_assign #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  mux_4to1_assign_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;
  logic [1:0]       sel_d, sel_q;
  logic             chg_d, chg_q;
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W-1:0] cnt_q [4];

  // Unknown select propagates X rather than falling back to a channel.
  always_comb begin
    case (bus.sel)
      2'b00:   out_c = bus.a;
      2'b01:   out_c = bus.b;
      2'b10:   out_c = bus.c;
      2'b11:   out_c = bus.d;
      default: out_c = 'x;
    endcase
  end

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    sel_d  = sel_q;
    chg_d  = 1'b0;
    cnt_d  = cnt_q;
    if (bus.en) begin
      data_d          = out_c;
      vld_d           = 1'b1;
      sel_d           = bus.sel;
      chg_d           = (bus.sel != sel_q);
      cnt_d[bus.sel]  = sat_inc(cnt_q[bus.sel]);
    end
  end

  // Registered stage: sample, strobe and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      sel_q  <= 2'b00;
      chg_q  <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      sel_q  <= sel_d;
      chg_q  <= chg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.out     = out_c;
  assign bus.out_q   = data_q;
  assign bus.out_vld = vld_q;
  assign bus.sel_chg = chg_q;
  assign bus.cnt_a   = cnt_q[0];
  assign bus.cnt_b   = cnt_q[1];
  assign bus.cnt_c   = cnt_q[2];
  assign bus.cnt_d   = cnt_q[3];

endmodule

// File: tb/tb_mux_4to1_assign.sv
// Bench for mux_4to1_assign: directed scenarios plus random traffic, checked
// against a behavioural model; a narrow-counter instance exercises saturation.
module tb_mux_4to1_assign;

  localparam int W     = 4;
  localparam int CW    = 8;
  localparam int CW2   = 2;
  localparam int MAX1  = (1 << CW) - 1;
  localparam int MAX2  = (1 << CW2) - 1;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   sel;

  int checks;
  int failures;

  // Reference model state
  logic [W-1:0] m_out_q;
  logic         m_vld;
  logic         m_chg;
  logic [1:0]   m_sel;
  int           m_cnt  [4];
  int           m2_cnt [4];

  mux_4to1_assign_if #(.WIDTH(W), .CNT_W(CW))  bus  ();
  mux_4to1_assign_if #(.WIDTH(W), .CNT_W(CW2)) bus2 ();

  assign bus.en  = en;  assign bus2.en  = en;
  assign bus.a   = a;   assign bus2.a   = a;
  assign bus.b   = b;   assign bus2.b   = b;
  assign bus.c   = c;   assign bus2.c   = c;
  assign bus.d   = d;   assign bus2.d   = d;
  assign bus.sel = sel; assign bus2.sel = sel;

  mux_4to1_assign #(.WIDTH(W), .CNT_W(CW))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  mux_4to1_assign #(.WIDTH(W), .CNT_W(CW2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_mux();
    logic [W-1:0] ch [4];
    ch = '{a, b, c, d};
    return ch[sel];
  endfunction

  task automatic model_reset();
    m_out_q = '0; m_vld = 1'b0; m_chg = 1'b0; m_sel = 2'b00;
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m2_cnt[i] = 0; end
  endtask

  task automatic model_clock();
    if (en) begin
      m_out_q = ref_mux();
      m_vld   = 1'b1;
      m_chg   = (sel != m_sel);
      m_sel   = sel;
      if (m_cnt[sel]  < MAX1) m_cnt[sel]++;
      if (m2_cnt[sel] < MAX2) m2_cnt[sel]++;
    end else begin
      m_chg = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".out"},      32'(bus.out),      32'(ref_mux()));
    check_eq({tag, ".out_q"},    32'(bus.out_q),    32'(m_out_q));
    check_eq({tag, ".out_vld"},  32'(bus.out_vld),  32'(m_vld));
    check_eq({tag, ".sel_chg"},  32'(bus.sel_chg),  32'(m_chg));
    check_eq({tag, ".cnt_a"},    32'(bus.cnt_a),    32'(m_cnt[0]));
    check_eq({tag, ".cnt_b"},    32'(bus.cnt_b),    32'(m_cnt[1]));
    check_eq({tag, ".cnt_c"},    32'(bus.cnt_c),    32'(m_cnt[2]));
    check_eq({tag, ".cnt_d"},    32'(bus.cnt_d),    32'(m_cnt[3]));
    check_eq({tag, ".n.out_q"},  32'(bus2.out_q),   32'(m_out_q));
    check_eq({tag, ".n.cnt_a"},  32'(bus2.cnt_a),   32'(m2_cnt[0]));
    check_eq({tag, ".n.cnt_b"},  32'(bus2.cnt_b),   32'(m2_cnt[1]));
    check_eq({tag, ".n.cnt_c"},  32'(bus2.cnt_c),   32'(m2_cnt[2]));
    check_eq({tag, ".n.cnt_d"},  32'(bus2.cnt_d),   32'(m2_cnt[3]));
  endtask

  // One clock: model follows the edge, outputs sampled 1 unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    check_all(tag);
  endtask

  initial begin
    checks = 0; failures = 0;
    model_reset();
    rst_n = 1'b1; en = 1'b0; sel = 2'b00;
    a = 4'b0000; b = 4'b0101; c = 4'b1010; d = 4'b1111;
    #1 rst_n = 1'b0;
    #1 check_all("reset");

    // Combinational path works with reset held, including through clock edges.
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1 check_eq("comb_sweep", 32'(bus.out), 32'(4'b0101 * i));
      #19;
    end
    check_all("reset_held");

    @(posedge clk); #1 rst_n = 1'b1;

    // Select change 00 -> 01 with enable
    en = 1'b1; sel = 2'b00;
    step("en_sel00");
    check_eq("first_chg", 32'(bus.sel_chg), 32'd0);
    sel = 2'b01;
    step("en_sel01");
    check_eq("chg_pulse", 32'(bus.sel_chg), 32'd1);
    check_eq("outq_0101", 32'(bus.out_q), 32'(4'b0101));
    step("en_hold01");
    check_eq("chg_drop", 32'(bus.sel_chg), 32'd0);

    // Enable low: registers hold while out tracks sel
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(3 - i);
      #1 check_eq("en0_comb", 32'(bus.out), 32'(ref_mux()));
      step("en0_sweep");
    end

    // Reset pulse between edges while enabled
    en = 1'b1; sel = 2'b11;
    step("pre_rst");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("mid_rst");
    check_eq("mid_rst_out", 32'(bus.out), 32'(4'b1111));
    #2 rst_n = 1'b1;

    // Saturation on the narrow-counter instance
    sel = 2'b10;
    for (int i = 0; i < 6; i++) step("sat");
    check_eq("sat_cnt_c",  32'(bus2.cnt_c), 32'd3);
    check_eq("sat_cnt_a",  32'(bus2.cnt_a), 32'd0);
    check_eq("sat_cnt_b",  32'(bus2.cnt_b), 32'd0);
    check_eq("sat_cnt_d",  32'(bus2.cnt_d), 32'd0);
    check_eq("wide_cnt_c", 32'(bus.cnt_c),  32'd6);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      a   = 4'($urandom);
      b   = 4'($urandom);
      c   = 4'($urandom);
      d   = 4'($urandom);
      sel = 2'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      #1 check_eq("rnd_comb", 32'(bus.out), 32'(ref_mux()));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
